// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer and its lane aligner.
package lsu_ctrl_pkg;

   localparam int LSU_XLEN = 32;
   localparam int MASK_W   = 8;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_X = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   // An access is refused when it is not naturally aligned or uses the reserved size code
   function automatic logic isIllegal(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the EXU request, memory-access and WBU result signals around lsu_ctrl.
interface lsu_ctrl_if
   import lsu_ctrl_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
);

   logic              exu_valid_i;
   logic              exu_ready_o;
   logic              exu_is_load_i;
   logic [1:0]        exu_size_i;
   logic              exu_signed_i;
   logic [XLEN-1:0]   exu_addr_i;
   logic [XLEN-1:0]   exu_wdata_i;
   logic [4:0]        exu_rd_i;

   logic              mem_ren_o;
   logic              mem_wen_o;
   logic              mem_signed_o;
   logic [XLEN-1:0]   mem_addr_o;
   logic [MASK_W-1:0] mem_mask_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic [XLEN-1:0]   mem_rdata_i;

   logic              wbu_valid_o;
   logic              wbu_ready_i;
   logic [XLEN-1:0]   wbu_data_o;
   logic [4:0]        wbu_rd_o;
   logic              wbu_misalign_o;

   modport slave (
      input  exu_valid_i, exu_is_load_i, exu_size_i, exu_signed_i,
             exu_addr_i, exu_wdata_i, exu_rd_i, mem_rdata_i, wbu_ready_i,
      output exu_ready_o, mem_ren_o, mem_wen_o, mem_signed_o, mem_addr_o,
             mem_mask_o, mem_wdata_o, wbu_valid_o, wbu_data_o, wbu_rd_o,
             wbu_misalign_o
   );

   modport master (
      output exu_valid_i, exu_is_load_i, exu_size_i, exu_signed_i,
             exu_addr_i, exu_wdata_i, exu_rd_i, mem_rdata_i, wbu_ready_i,
      input  exu_ready_o, mem_ren_o, mem_wen_o, mem_signed_o, mem_addr_o,
             mem_mask_o, mem_wdata_o, wbu_valid_o, wbu_data_o, wbu_rd_o,
             wbu_misalign_o
   );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: builds the store strobe and shifted write data, and
// pulls a load value out of its lane with sign or zero extension.
module lsu_align
   import lsu_ctrl_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
) (
   input  size_e             stSize_i,
   input  logic [1:0]        stOff_i,
   input  logic [XLEN-1:0]   stData_i,
   output logic [MASK_W-1:0] stMask_o,
   output logic [XLEN-1:0]   stData_o,
   input  size_e             ldSize_i,
   input  logic [1:0]        ldOff_i,
   input  logic              ldSigned_i,
   input  logic [XLEN-1:0]   ldData_i,
   output logic [XLEN-1:0]   ldData_o
);

   logic [3:0]      laneMask;
   logic [XLEN-1:0] ldShifted;

   assign stMask_o  = {{(MASK_W-4){1'b0}}, laneMask};
   assign stData_o  = stData_i << {stOff_i, 3'b000};
   assign ldShifted = ldData_i >> {ldOff_i, 3'b000};

   // Strobe covers the bytes touched by the access, starting at the byte offset
   always_comb begin
      laneMask = 4'hF;
      case (stSize_i)
         SZ_B:    laneMask = 4'b0001 << stOff_i;
         SZ_H:    laneMask = 4'b0011 << stOff_i;
         default: laneMask = 4'hF;
      endcase
   end

   // Truncate the lane-shifted word to the access size and extend it back to XLEN
   always_comb begin
      ldData_o = ldShifted;
      case (ldSize_i)
         SZ_B:    ldData_o = {{(XLEN-8){ldSigned_i & ldShifted[7]}}, ldShifted[7:0]};
         SZ_H:    ldData_o = {{(XLEN-16){ldSigned_i & ldShifted[15]}}, ldShifted[15:0]};
         default: ldData_o = ldShifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one op from EXU, holds the memory access for
// MEM_LAT cycles, then hands the aligned/extended result to WBU.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int XLEN    = LSU_XLEN,
   parameter int MEM_LAT = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   lsu_ctrl_if.slave bus
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              isLoad_q;
   size_e             size_q;
   logic              signed_q;
   logic [1:0]        off_q;
   logic [4:0]        rd_q;

   logic              exuReady_q;
   logic              memRen_q;
   logic              memWen_q;
   logic [XLEN-1:0]   memAddr_q;
   logic [MASK_W-1:0] memMask_q;
   logic [XLEN-1:0]   memWdata_q;
   logic              wbuValid_q;
   logic [XLEN-1:0]   wbuData_q;
   logic [4:0]        wbuRd_q;
   logic              wbuMisalign_q;

   logic [MASK_W-1:0] laneMask_d;
   logic [XLEN-1:0]   laneWdata_d;
   logic [XLEN-1:0]   loadData_d;

   lsu_align #(.XLEN(XLEN)) uAlign (
      .stSize_i   (size_e'(bus.exu_size_i)),
      .stOff_i    (bus.exu_addr_i[1:0]),
      .stData_i   (bus.exu_wdata_i),
      .stMask_o   (laneMask_d),
      .stData_o   (laneWdata_d),
      .ldSize_i   (size_q),
      .ldOff_i    (off_q),
      .ldSigned_i (signed_q),
      .ldData_i   (bus.mem_rdata_i),
      .ldData_o   (loadData_d)
   );

   assign bus.exu_ready_o    = exuReady_q;
   assign bus.mem_ren_o      = memRen_q;
   assign bus.mem_wen_o      = memWen_q;
   assign bus.mem_signed_o   = 1'b0;
   assign bus.mem_addr_o     = memAddr_q;
   assign bus.mem_mask_o     = memMask_q;
   assign bus.mem_wdata_o    = memWdata_q;
   assign bus.wbu_valid_o    = wbuValid_q;
   assign bus.wbu_data_o     = wbuData_q;
   assign bus.wbu_rd_o       = wbuRd_q;
   assign bus.wbu_misalign_o = wbuMisalign_q;

   // Sequencer: accept in IDLE, hold the access while counting down, then present the result until WBU takes it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         isLoad_q      <= 1'b0;
         size_q        <= SZ_B;
         signed_q      <= 1'b0;
         off_q         <= 2'b00;
         rd_q          <= 5'd0;
         exuReady_q    <= 1'b1;
         memRen_q      <= 1'b0;
         memWen_q      <= 1'b0;
         memAddr_q     <= '0;
         memMask_q     <= '0;
         memWdata_q    <= '0;
         wbuValid_q    <= 1'b0;
         wbuData_q     <= '0;
         wbuRd_q       <= 5'd0;
         wbuMisalign_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.exu_valid_i) begin
                  isLoad_q   <= bus.exu_is_load_i;
                  size_q     <= size_e'(bus.exu_size_i);
                  signed_q   <= bus.exu_signed_i;
                  off_q      <= bus.exu_addr_i[1:0];
                  rd_q       <= bus.exu_rd_i;
                  exuReady_q <= 1'b0;
                  if (isIllegal(bus.exu_size_i, bus.exu_addr_i[1:0])) begin
                     state_q       <= RESP;
                     wbuValid_q    <= 1'b1;
                     wbuData_q     <= '0;
                     wbuMisalign_q <= 1'b1;
                     wbuRd_q       <= bus.exu_is_load_i ? bus.exu_rd_i : 5'd0;
                  end else begin
                     state_q    <= ACCESS;
                     cnt_q      <= CNT_W'(MEM_LAT - 1);
                     memRen_q   <= bus.exu_is_load_i;
                     memWen_q   <= ~bus.exu_is_load_i;
                     memAddr_q  <= {bus.exu_addr_i[XLEN-1:2], 2'b00};
                     memMask_q  <= laneMask_d;
                     memWdata_q <= laneWdata_d;
                  end
               end
            end
            ACCESS: begin
               memWen_q <= 1'b0;
               if (cnt_q == '0) begin
                  state_q       <= RESP;
                  memRen_q      <= 1'b0;
                  memAddr_q     <= '0;
                  memMask_q     <= '0;
                  memWdata_q    <= '0;
                  wbuValid_q    <= 1'b1;
                  wbuData_q     <= isLoad_q ? loadData_d : '0;
                  wbuRd_q       <= isLoad_q ? rd_q : 5'd0;
                  wbuMisalign_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (bus.wbu_ready_i) begin
                  state_q       <= IDLE;
                  exuReady_q    <= 1'b1;
                  wbuValid_q    <= 1'b0;
                  wbuData_q     <= '0;
                  wbuRd_q       <= 5'd0;
                  wbuMisalign_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               exuReady_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, randomized ops
// against a reference model, reset abort and MEM_LAT=1 back-to-back traffic.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   typedef struct {
      logic        isLoad;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          stall;
      logic        expIllegal;
      logic [7:0]  expMask;
      logic [31:0] expWdata;
      logic [31:0] expData;
      logic [4:0]  expRd;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   nChecks = 0;
   int   nFail   = 0;
   int   wenTotal;

   always #5 clk = ~clk;

   lsu_ctrl_if #(.XLEN(32)) busA();
   lsu_ctrl_if #(.XLEN(32)) busB();

   lsu_ctrl #(.XLEN(32), .MEM_LAT(LAT_A)) dutA (.clk_i(clk), .rst_i(rst), .bus(busA.slave));
   lsu_ctrl #(.XLEN(32), .MEM_LAT(LAT_B)) dutB (.clk_i(clk), .rst_i(rst), .bus(busB.slave));

   // Counts every cycle in which the first DUT is writing memory
   always @(negedge clk) begin
      if (busA.mem_wen_o) wenTotal++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected results from the access rules: natural alignment, byte strobes and arithmetic extension
   function automatic vec_t model(input vec_t v);
      vec_t   r;
      int     bytes;
      int     off;
      longint raw;
      r     = v;
      bytes = 1 << v.size;
      off   = int'(v.addr[1:0]);
      r.expIllegal = (v.size == 2'd3) || ((off % bytes) != 0);
      r.expMask    = 8'h00;
      r.expWdata   = 32'h0;
      r.expData    = 32'h0;
      r.expRd      = v.isLoad ? v.rd : 5'd0;
      if (!r.expIllegal) begin
         r.expMask  = 8'(((1 << bytes) - 1) << off);
         r.expWdata = v.wdata << (8 * off);
         if (v.isLoad) begin
            raw = (longint'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * bytes)) - 64'd1);
            if (v.sgn && bytes < 4 && raw[8*bytes-1]) raw = raw - (64'sd1 << (8 * bytes));
            r.expData = raw[31:0];
         end
      end
      return r;
   endfunction

   task automatic checkResp(input vec_t v, input string tag);
      checkOutput({tag, "_wbu_valid"}, 32'(busA.wbu_valid_o), 32'd1);
      checkOutput({tag, "_wbu_data"}, busA.wbu_data_o, v.expData);
      checkOutput({tag, "_wbu_rd"}, 32'(busA.wbu_rd_o), 32'(v.expRd));
      checkOutput({tag, "_misalign"}, 32'(busA.wbu_misalign_o), 32'(v.expIllegal));
      checkOutput({tag, "_resp_en"}, 32'({busA.mem_ren_o, busA.mem_wen_o}), 32'd0);
      checkOutput({tag, "_resp_exu_ready"}, 32'(busA.exu_ready_o), 32'd0);
   endtask

   // One complete op on the MEM_LAT=2 instance, entered and left #1 after a rising edge with the DUT idle
   task automatic applyStimulus(input vec_t v, input string tag);
      int lat;
      int wenCycles;
      int renCycles;
      logic [31:0] expAddr;
      expAddr = v.addr & 32'hFFFF_FFFC;
      checkOutput({tag, "_exu_ready_idle"}, 32'(busA.exu_ready_o), 32'd1);
      busA.exu_valid_i   = 1'b1;
      busA.exu_is_load_i = v.isLoad;
      busA.exu_size_i    = v.size;
      busA.exu_signed_i  = v.sgn;
      busA.exu_addr_i    = v.addr;
      busA.exu_wdata_i   = v.wdata;
      busA.exu_rd_i      = v.rd;
      busA.mem_rdata_i   = v.rdata;
      busA.wbu_ready_i   = 1'b0;
      @(posedge clk); #1;
      busA.exu_valid_i   = 1'b0;
      busA.exu_is_load_i = 1'($urandom);
      busA.exu_size_i    = 2'($urandom);
      busA.exu_signed_i  = 1'($urandom);
      busA.exu_addr_i    = $urandom;
      busA.exu_wdata_i   = $urandom;
      busA.exu_rd_i      = 5'($urandom);
      lat = 1;
      wenCycles = 0;
      renCycles = 0;
      while (!busA.wbu_valid_o && lat < 40) begin
         if (busA.mem_wen_o) wenCycles++;
         if (busA.mem_ren_o) renCycles++;
         if (busA.mem_ren_o || busA.mem_wen_o) begin
            checkOutput({tag, "_mem_addr"}, busA.mem_addr_o, expAddr);
            checkOutput({tag, "_mem_mask"}, 32'(busA.mem_mask_o), 32'(v.expMask));
            checkOutput({tag, "_mem_wdata"}, busA.mem_wdata_o, v.expWdata);
            checkOutput({tag, "_mem_signed"}, 32'(busA.mem_signed_o), 32'd0);
         end
         checkOutput({tag, "_exu_ready_busy"}, 32'(busA.exu_ready_o), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), v.expIllegal ? 32'd1 : 32'(LAT_A + 1));
      checkOutput({tag, "_wen_cycles"}, 32'(wenCycles), (!v.expIllegal && !v.isLoad) ? 32'd1 : 32'd0);
      checkOutput({tag, "_ren_cycles"}, 32'(renCycles), (!v.expIllegal && v.isLoad) ? 32'(LAT_A) : 32'd0);
      checkResp(v, tag);
      for (int s = 0; s < v.stall; s++) begin
         busA.mem_rdata_i = $urandom;
         @(posedge clk); #1;
         checkResp(v, {tag, "_stall"});
      end
      busA.wbu_ready_i = 1'b1;
      @(posedge clk); #1;
      busA.wbu_ready_i = 1'b0;
      checkOutput({tag, "_done_valid"}, 32'(busA.wbu_valid_o), 32'd0);
      checkOutput({tag, "_done_exu_ready"}, 32'(busA.exu_ready_o), 32'd1);
   endtask

   // Hard stop in case the DUT never lets the bench make progress
   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vec_t vecs[10];
      vec_t v;
      int   got;
      int   lastCyc;
      logic acc;

      vecs[0] = '{1'b1, 2'd0, 1'b1, 32'h80000003, 32'h000000AA, 5'd5,  32'h80FF1234, 0, 1'b0, 8'h08, 32'hAA000000, 32'hFFFFFF80, 5'd5};
      vecs[1] = '{1'b0, 2'd1, 1'b0, 32'h80000002, 32'h0000BEEF, 5'd7,  32'h11223344, 1, 1'b0, 8'h0C, 32'hBEEF0000, 32'h00000000, 5'd0};
      vecs[2] = '{1'b1, 2'd2, 1'b0, 32'h80000006, 32'h00000000, 5'd9,  32'h55555555, 0, 1'b1, 8'h00, 32'h00000000, 32'h00000000, 5'd9};
      vecs[3] = '{1'b1, 2'd1, 1'b0, 32'h80000000, 32'h00000000, 5'd12, 32'h1234F00D, 5, 1'b0, 8'h03, 32'h00000000, 32'h0000F00D, 5'd12};
      vecs[4] = '{1'b1, 2'd1, 1'b1, 32'h80000002, 32'h00000000, 5'd1,  32'h9ABC0000, 2, 1'b0, 8'h0C, 32'h00000000, 32'hFFFF9ABC, 5'd1};
      vecs[5] = '{1'b1, 2'd0, 1'b0, 32'h00000101, 32'h00000000, 5'd31, 32'h0000F100, 0, 1'b0, 8'h02, 32'h00000000, 32'h000000F1, 5'd31};
      vecs[6] = '{1'b0, 2'd2, 1'b0, 32'h10000004, 32'hDEADBEEF, 5'd4,  32'h00000000, 0, 1'b0, 8'h0F, 32'hDEADBEEF, 32'h00000000, 5'd0};
      vecs[7] = '{1'b1, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 5'd3,  32'h00000000, 0, 1'b1, 8'h00, 32'h00000000, 32'h00000000, 5'd3};
      vecs[8] = '{1'b0, 2'd1, 1'b0, 32'h00000003, 32'h00001234, 5'd6,  32'h00000000, 1, 1'b1, 8'h00, 32'h00000000, 32'h00000000, 5'd0};
      vecs[9] = '{1'b0, 2'd0, 1'b0, 32'h00000001, 32'hFFFFFF5A, 5'd2,  32'h00000000, 0, 1'b0, 8'h02, 32'hFFFF5A00, 32'h00000000, 5'd0};

      rst = 1'b1;
      wenTotal = 0;
      busA.exu_valid_i = 1'b0; busA.exu_is_load_i = 1'b0; busA.exu_size_i = 2'd0; busA.exu_signed_i = 1'b0;
      busA.exu_addr_i = 32'h0; busA.exu_wdata_i = 32'h0; busA.exu_rd_i = 5'd0; busA.mem_rdata_i = 32'h0; busA.wbu_ready_i = 1'b0;
      busB.exu_valid_i = 1'b0; busB.exu_is_load_i = 1'b0; busB.exu_size_i = 2'd0; busB.exu_signed_i = 1'b0;
      busB.exu_addr_i = 32'h0; busB.exu_wdata_i = 32'h0; busB.exu_rd_i = 5'd0; busB.mem_rdata_i = 32'h0; busB.wbu_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_exu_ready", 32'(busA.exu_ready_o), 32'd1);
      checkOutput("rst_mem_en", 32'({busA.mem_ren_o, busA.mem_wen_o, busA.mem_signed_o}), 32'd0);
      checkOutput("rst_mem_addr", busA.mem_addr_o, 32'd0);
      checkOutput("rst_mem_mask", 32'(busA.mem_mask_o), 32'd0);
      checkOutput("rst_mem_wdata", busA.mem_wdata_o, 32'd0);
      checkOutput("rst_wbu_ctl", 32'({busA.wbu_valid_o, busA.wbu_misalign_o, busA.wbu_rd_o}), 32'd0);
      checkOutput("rst_wbu_data", busA.wbu_data_o, 32'd0);
      checkOutput("rstB_exu_ready", 32'(busB.exu_ready_o), 32'd1);

      $display("[TB] directed vector table");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      $display("[TB] randomized ops against reference model");
      for (int i = 0; i < 40; i++) begin
         v.isLoad = 1'($urandom_range(0, 1));
         v.size   = 2'($urandom_range(0, 3));
         v.sgn    = 1'($urandom_range(0, 1));
         v.addr   = $urandom;
         v.wdata  = $urandom;
         v.rd     = 5'($urandom);
         v.rdata  = $urandom;
         v.stall  = $urandom_range(0, 3);
         v = model(v);
         applyStimulus(v, $sformatf("rnd%0d", i));
      end

      $display("[TB] reset during store access");
      busA.exu_valid_i = 1'b1; busA.exu_is_load_i = 1'b0; busA.exu_size_i = 2'd2;
      busA.exu_addr_i = 32'h00000020; busA.exu_wdata_i = 32'h12345678; busA.exu_rd_i = 5'd8;
      @(posedge clk); #1;
      busA.exu_valid_i = 1'b0;
      checkOutput("abort_wen_before", 32'(busA.mem_wen_o), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wenTotal = 0;
      checkOutput("abort_exu_ready", 32'(busA.exu_ready_o), 32'd1);
      checkOutput("abort_mem_en", 32'({busA.mem_ren_o, busA.mem_wen_o}), 32'd0);
      checkOutput("abort_mem_addr", busA.mem_addr_o, 32'd0);
      checkOutput("abort_mem_mask", 32'(busA.mem_mask_o), 32'd0);
      checkOutput("abort_mem_wdata", busA.mem_wdata_o, 32'd0);
      checkOutput("abort_wbu_ctl", 32'({busA.wbu_valid_o, busA.wbu_misalign_o, busA.wbu_rd_o}), 32'd0);
      checkOutput("abort_wbu_data", busA.wbu_data_o, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("abort_no_wen", 32'(wenTotal), 32'd0);
      checkOutput("abort_stays_idle", 32'({busA.wbu_valid_o, busA.exu_ready_o}), 32'd1);

      $display("[TB] MEM_LAT=1 back-to-back loads");
      busB.exu_is_load_i = 1'b1; busB.exu_size_i = 2'd2; busB.exu_signed_i = 1'b0;
      busB.exu_addr_i = 32'h00000040; busB.mem_rdata_i = 32'hCAFE0001;
      busB.exu_rd_i = 5'd1; busB.wbu_ready_i = 1'b1; busB.exu_valid_i = 1'b1;
      got = 0;
      lastCyc = -1;
      for (int c = 0; c < 60 && got < 4; c++) begin
         acc = busB.exu_valid_i && busB.exu_ready_o;
         if (busB.wbu_valid_o) begin
            checkOutput("b2b_rd", 32'(busB.wbu_rd_o), 32'(got + 1));
            checkOutput("b2b_data", busB.wbu_data_o, 32'hCAFE0001);
            checkOutput("b2b_no_overlap", 32'(busB.exu_ready_o), 32'd0);
            if (got > 0) checkOutput("b2b_spacing", 32'(c - lastCyc), 32'd3);
            lastCyc = c;
            got++;
         end
         @(posedge clk); #1;
         if (acc) busB.exu_rd_i = busB.exu_rd_i + 5'd1;
      end
      busB.exu_valid_i = 1'b0;
      busB.wbu_ready_i = 1'b0;
      checkOutput("b2b_results", 32'(got), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
